mem_responder: RTL and testbench

- Memory-side responder for the pipelined CPU's bus: one fetch read port, one data read/write port with byte lanes, and the 16-bit interrupt vector the core consumes.
- Holds the unified word RAM plus a small MMIO page containing a UART transmit FIFO, a down-counting timer and an interrupt pending/mask pair.
- Sits beside the core at the top level, driven by the core's clk_en so CPU-visible state advances in lockstep with the pipeline.

---
 rtl/mem_map_pkg.sv | 56 +++++
 rtl/byte_fifo.sv | 75 +++++++
 rtl/mem_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg
//   Shared definitions for the memory responder: MMIO register offsets,
//   interrupt bit indices, STATUS bit positions, timer control layout,
//   read-source selector and a byte-lane merge helper.
package mem_map_pkg;

  // Word offsets of the MMIO registers relative to the MMIO base address.
  typedef enum logic [2:0] {
    REG_TX          = 3'd0,
    REG_STATUS      = 3'd1,
    REG_TIMER_LOAD  = 3'd2,
    REG_TIMER_COUNT = 3'd3,
    REG_TIMER_CTRL  = 3'd4,
    REG_IRQ_PENDING = 3'd5,
    REG_IRQ_MASK    = 3'd6
  } mmio_reg_e;

  // Number of decoded words in the MMIO page.
  localparam logic [17:0] MMIO_SPAN = 18'd7;

  // Interrupt pending/mask bit indices.
  localparam int IRQ_TIMER    = 0;
  localparam int IRQ_TX_EMPTY = 1;

  // STATUS register bit positions.
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 4;

  // TIMER_CTRL layout: bit0 enable, bit1 auto-reload.
  typedef struct packed {
    logic auto_reload;
    logic enable;
  } timer_ctrl_t;

  // Where a registered read result comes from.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_MMIO = 2'd2
  } rd_src_e;

  // Replace the bytes of old_word selected by lanes with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Byte-wide circular FIFO with a registered head byte. Accepts a push and
//   a pop on the same edge even when full (count unchanged).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push, push_data  push request and byte
//   pop          pop request (ignored when empty)
//   head         registered oldest byte (0 when empty)
//   empty, full  occupancy flags
//   count        number of stored bytes
//   drain        high when this edge takes the FIFO from non-empty to empty
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drain
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_next;
  logic [PW:0]   count_next;
  logic [7:0]    head_next;
  logic          pop_ok, push_ok;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A push into a full FIFO is only accepted when a pop frees the slot on
  // the same edge. The next head is the byte being written when the new
  // read pointer lands on the write slot (empty FIFO, or single byte popped).
  always_comb begin
    pop_ok      = pop && (count != '0);
    push_ok     = push && ((count != FULL_COUNT) || pop_ok);
    rd_ptr_next = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
    count_next  = count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    drain       = pop_ok && !push_ok && (count == (PW+1)'(1));
    if (count_next == '0) begin
      head_next = 8'h00;
    end else if (push_ok && (wr_ptr == rd_ptr_next)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= 8'h00;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= push_ok ? wr_ptr + PW'(1) : wr_ptr;
      count  <= count_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the pipelined core: word RAM with a fetch port
//   and a byte-lane data port, plus an MMIO page with a UART TX FIFO, a
//   down-counting timer and an interrupt pending/mask pair.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clk_en               CPU step enable (gates CPU reads/writes and timer)
//   mem_read0_addr/data  fetch port (registered data)
//   mem_re, mem_read1_addr/data  data-port read (data held when mem_re=0)
//   mem_we, mem_write_addr/data  byte-lane write
//   interrupts           registered pending & mask
//   tx_data, tx_valid, tx_ready  UART byte stream (valid/ready)
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS = 16384,
  parameter logic [17:0] MMIO_BASE = 18'h3FF00,
  parameter int          TX_DEPTH  = 16,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [17:0] mem_read0_addr,
  output logic [31:0] mem_read0_data,
  input  logic        mem_re,
  input  logic [17:0] mem_read1_addr,
  output logic [31:0] mem_read1_data,
  input  logic [3:0]  mem_we,
  input  logic [17:0] mem_write_addr,
  input  logic [31:0] mem_write_data,
  output logic [15:0] interrupts,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0] ram [RAM_WORDS];

  function automatic logic is_mmio(input logic [17:0] a);
    return (a >= MMIO_BASE) && ((a - MMIO_BASE) < MMIO_SPAN);
  endfunction

  // MMIO takes priority should the page ever overlap the RAM range.
  function automatic logic is_ram(input logic [17:0] a);
    return ({14'd0, a} < 32'(RAM_WORDS)) && !is_mmio(a);
  endfunction

  // Decode
  logic        rd0_ram, rd1_ram, rd1_mmio, wr_ram, wr_mmio;
  mmio_reg_e   rd_off, wr_off;

  assign rd0_ram  = is_ram(mem_read0_addr);
  assign rd1_ram  = is_ram(mem_read1_addr);
  assign rd1_mmio = is_mmio(mem_read1_addr);
  assign wr_ram   = clk_en && (mem_we != 4'b0000) && is_ram(mem_write_addr);
  assign wr_mmio  = clk_en && (mem_we != 4'b0000) && is_mmio(mem_write_addr);
  // Low three bits of the offset only depend on the low three address bits.
  assign rd_off   = mmio_reg_e'(mem_read1_addr[2:0] - MMIO_BASE[2:0]);
  assign wr_off   = mmio_reg_e'(mem_write_addr[2:0] - MMIO_BASE[2:0]);

  // MMIO state
  timer_ctrl_t timer_ctrl, ctrl_next;
  logic [31:0] timer_load, load_next, timer_count, count_next;
  logic [15:0] irq_pending, pending_next, irq_mask, mask_next;
  logic [15:0] w1c_bits, set_bits;
  logic        overflow, overflow_next, timer_fire;

  // FIFO interface
  logic          tx_push, tx_pop, fifo_empty, fifo_full, fifo_drain;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word, mmio_rdata;

  assign tx_push  = wr_mmio && (wr_off == REG_TX) && mem_we[0];
  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (mem_write_data[7:0]),
    .pop       (tx_pop),
    .head      (tx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .drain     (fifo_drain)
  );

  always_comb begin
    status_word                            = '0;
    status_word[STAT_EMPTY]                = fifo_empty;
    status_word[STAT_FULL]                 = fifo_full;
    status_word[STAT_OVERFLOW]             = overflow;
    status_word[STAT_COUNT_LSB +: CW]      = fifo_count;
  end

  always_comb begin
    case (rd_off)
      REG_STATUS:      mmio_rdata = status_word;
      REG_TIMER_LOAD:  mmio_rdata = timer_load;
      REG_TIMER_COUNT: mmio_rdata = timer_count;
      REG_TIMER_CTRL:  mmio_rdata = {30'd0, timer_ctrl};
      REG_IRQ_PENDING: mmio_rdata = {16'd0, irq_pending};
      REG_IRQ_MASK:    mmio_rdata = {16'd0, irq_mask};
      default:         mmio_rdata = 32'd0;
    endcase
  end

  // RAM array: no reset so it maps onto block RAM. Non-blocking reads give
  // read-first behaviour against a same-edge write.
  logic [31:0] ram_q0, ram_q1, mmio_q1;
  rd_src_e     src0, src1;

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (wr_ram) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_we[i]) ram[mem_write_addr[AW-1:0]][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
      end
      ram_q0 <= ram[mem_read0_addr[AW-1:0]];
      if (mem_re) ram_q1 <= ram[mem_read1_addr[AW-1:0]];
    end
  end

  // The source selectors carry the reset, so outputs read 0 after reset
  // without needing to clear the RAM output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      src0    <= RD_ZERO;
      src1    <= RD_ZERO;
      mmio_q1 <= 32'd0;
    end else if (clk_en) begin
      src0 <= rd0_ram ? RD_RAM : RD_ZERO;
      if (mem_re) begin
        src1    <= rd1_mmio ? RD_MMIO : (rd1_ram ? RD_RAM : RD_ZERO);
        mmio_q1 <= mmio_rdata;
      end
    end
  end

  assign mem_read0_data = (src0 == RD_RAM) ? ram_q0 : 32'd0;

  always_comb begin
    case (src1)
      RD_RAM:  mem_read1_data = ram_q1;
      RD_MMIO: mem_read1_data = mmio_q1;
      default: mem_read1_data = 32'd0;
    endcase
  end

  // Timer step and register writes. A CPU write to TIMER_CTRL overrides the
  // timer's own enable/count update on the same edge. Interrupt set sources
  // are OR-ed in after the W1C clear so a coincident set wins.
  always_comb begin
    load_next     = timer_load;
    count_next    = timer_count;
    ctrl_next     = timer_ctrl;
    mask_next     = irq_mask;
    overflow_next = overflow;
    w1c_bits      = '0;
    set_bits      = '0;
    timer_fire    = clk_en && timer_ctrl.enable && (timer_count == 32'd0);

    if (clk_en && timer_ctrl.enable) begin
      if (timer_count != 32'd0) begin
        count_next = timer_count - 32'd1;
      end else if (timer_ctrl.auto_reload) begin
        count_next = timer_load;
      end else begin
        ctrl_next.enable = 1'b0;
      end
    end

    if (tx_push && fifo_full && !tx_pop) overflow_next = 1'b1;

    if (wr_mmio) begin
      case (wr_off)
        REG_STATUS: begin
          if (mem_we[0] && mem_write_data[STAT_OVERFLOW]) overflow_next = 1'b0;
        end
        REG_TIMER_LOAD: load_next = merge_lanes(timer_load, mem_write_data, mem_we);
        REG_TIMER_CTRL: begin
          if (mem_we[0]) begin
            ctrl_next = timer_ctrl_t'(mem_write_data[1:0]);
            if (mem_write_data[0]) count_next = timer_load;
          end
        end
        REG_IRQ_PENDING: begin
          for (int i = 0; i < 2; i++) begin
            if (mem_we[i]) w1c_bits[8*i +: 8] = mem_write_data[8*i +: 8];
          end
        end
        REG_IRQ_MASK: begin
          for (int i = 0; i < 2; i++) begin
            if (mem_we[i]) mask_next[8*i +: 8] = mem_write_data[8*i +: 8];
          end
        end
        default: ;
      endcase
    end

    set_bits[IRQ_TIMER]    = timer_fire;
    set_bits[IRQ_TX_EMPTY] = fifo_drain;
    pending_next           = (irq_pending & ~w1c_bits) | set_bits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_load  <= 32'd0;
      timer_count <= 32'd0;
      timer_ctrl  <= '0;
      irq_pending <= 16'd0;
      irq_mask    <= 16'd0;
      overflow    <= 1'b0;
      interrupts  <= 16'd0;
    end else begin
      timer_load  <= load_next;
      timer_count <= count_next;
      timer_ctrl  <= ctrl_next;
      irq_pending <= pending_next;
      irq_mask    <= mask_next;
      overflow    <= overflow_next;
      interrupts  <= irq_pending & irq_mask;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Scoreboard bench for mem_responder: port-1 reads and UART bytes are
//   queued as expectations when issued and checked by independent monitors.
module tb_mem_responder;

  logic        clk, rst, clk_en, mem_re, tx_valid, tx_ready;
  logic [17:0] mem_read0_addr, mem_read1_addr, mem_write_addr;
  logic [31:0] mem_read0_data, mem_read1_data, mem_write_data;
  logic [3:0]  mem_we;
  logic [15:0] interrupts;
  logic [7:0]  tx_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_expect_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_expect_q[$];
  logic        rd_due = 1'b0;

  localparam logic [17:0] A_TX     = 18'h3FF00;
  localparam logic [17:0] A_STATUS = 18'h3FF01;
  localparam logic [17:0] A_LOAD   = 18'h3FF02;
  localparam logic [17:0] A_COUNT  = 18'h3FF03;
  localparam logic [17:0] A_CTRL   = 18'h3FF04;
  localparam logic [17:0] A_PEND   = 18'h3FF05;
  localparam logic [17:0] A_MASK   = 18'h3FF06;

  mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .mem_read0_addr (mem_read0_addr),
    .mem_read0_data (mem_read0_data),
    .mem_re         (mem_re),
    .mem_read1_addr (mem_read1_addr),
    .mem_read1_data (mem_read1_data),
    .mem_we         (mem_we),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .interrupts     (interrupts),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Read monitor: a port-1 read accepted on a posedge is checked at the
  // following negedge against the oldest queued expectation.
  always @(posedge clk) rd_due = clk_en && mem_re && !rst;

  always @(negedge clk) begin
    logic [31:0] exp_word;
    string       nm;
    logic [7:0]  exp_byte;
    if (rd_due) begin
      if (rd_expect_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rd1_unexpected actual=%h required=none", mem_read1_data);
      end else begin
        exp_word = rd_expect_q.pop_front();
        nm       = rd_name_q.pop_front();
        checkOutput(nm, mem_read1_data, exp_word);
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_expect_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL tx_unexpected actual=%h required=none", tx_data);
      end else begin
        exp_byte = tx_expect_q.pop_front();
        checkOutput("tx_byte", {24'd0, tx_data}, {24'd0, exp_byte});
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic re, input logic [17:0] a0,
                               input logic [17:0] a1, input logic [3:0] we,
                               input logic [31:0] wd);
    clk_en         = en;
    mem_re         = re;
    mem_read0_addr = a0;
    mem_read1_addr = a1;
    mem_write_addr = a1;
    mem_we         = we;
    mem_write_data = wd;
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    mem_re = 1'b0;
    mem_we = 4'b0000;
  endtask

  task automatic wr(input logic [17:0] addr, input logic [3:0] we, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, mem_read0_addr, addr, we, data);
  endtask

  task automatic rd(input string name, input logic [17:0] addr, input logic [31:0] expected);
    rd_expect_q.push_back(expected);
    rd_name_q.push_back(name);
    applyStimulus(1'b1, 1'b1, addr, addr, 4'b0000, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, mem_read0_addr, mem_read1_addr, 4'b0000, 32'd0);
  endtask

  task automatic pushTx(input logic [7:0] b, input logic expect_out);
    if (expect_out) tx_expect_q.push_back(b);
    wr(A_TX, 4'b0001, {24'd0, b});
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; mem_re = 1'b0; mem_we = 4'b0000; tx_ready = 1'b0;
    mem_read0_addr = '0; mem_read1_addr = '0; mem_write_addr = '0; mem_write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_read0", mem_read0_data, 32'd0);
    checkOutput("reset_read1", mem_read1_data, 32'd0);
    checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_interrupts", {16'd0, interrupts}, 32'd0);
    rst = 1'b0; clk_en = 1'b1;

    $display("[TB] RAM byte-lane write");
    wr(18'h10, 4'b1111, 32'hDEADBEEF);
    wr(18'h10, 4'b0010, 32'h00005500);
    rd("ram_lane_merge", 18'h10, 32'hDEAD55EF);
    checkOutput("read0_ram", mem_read0_data, 32'hDEAD55EF);

    $display("[TB] read-first");
    wr(18'h20, 4'b1111, 32'h1);
    rd_expect_q.push_back(32'h1);
    rd_name_q.push_back("read_first_port1");
    applyStimulus(1'b1, 1'b1, 18'h20, 18'h20, 4'b1111, 32'h2);
    checkOutput("read_first_port0", mem_read0_data, 32'h1);
    rd("read_after_write", 18'h20, 32'h2);

    $display("[TB] unmapped address");
    wr(18'h04000, 4'b1111, 32'h12345678);
    rd("beyond_ram", 18'h04000, 32'd0);
    checkOutput("read0_beyond_ram", mem_read0_data, 32'd0);

    $display("[TB] clk_en gating");
    wr(A_LOAD, 4'b1111, 32'd100);
    wr(A_CTRL, 4'b1111, 32'd1);
    pushTx(8'hAA, 1'b1);
    pushTx(8'hBB, 1'b1);
    rd("gate_setup_read", 18'h10, 32'hDEAD55EF);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_en = 1'b0;
      mem_re = 1'b1;
      mem_read0_addr = 18'h30 + 18'(i);
      mem_read1_addr = 18'h20 + 18'(i);
      @(posedge clk);
      #1;
    end
    clk_en = 1'b1; mem_re = 1'b0; tx_ready = 1'b0;
    checkOutput("gated_read1_hold", mem_read1_data, 32'hDEAD55EF);
    checkOutput("gated_read0_hold", mem_read0_data, 32'hDEAD55EF);
    checkOutput("gated_fifo_drained", {31'd0, tx_valid}, 32'd0);
    rd("timer_count_frozen", A_COUNT, 32'd97);
    checkOutput("read0_mmio_zero", mem_read0_data, 32'd0);
    wr(A_CTRL, 4'b1111, 32'd0);

    $display("[TB] UART FIFO");
    wr(A_PEND, 4'b1111, 32'h0000FFFF);
    for (int i = 0; i < 17; i++) pushTx(8'(i), i < 16);
    rd("status_full_overflow", A_STATUS, 32'h0000_0106);
    checkOutput("tx_valid_full", {31'd0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    idle(18);
    tx_ready = 1'b0;
    checkOutput("tx_valid_drained", {31'd0, tx_valid}, 32'd0);
    checkOutput("irq_masked_off", {16'd0, interrupts}, 32'd0);
    wr(A_MASK, 4'b1111, 32'h2);
    idle(1);
    checkOutput("irq_tx_empty", {16'd0, interrupts}, 32'h2);
    rd("status_empty_overflow", A_STATUS, 32'h5);
    wr(A_STATUS, 4'b0001, 32'h4);
    rd("status_overflow_cleared", A_STATUS, 32'h1);
    rd("pending_tx_empty", A_PEND, 32'h2);
    wr(A_PEND, 4'b1111, 32'h2);
    wr(A_MASK, 4'b1111, 32'h0);

    $display("[TB] timer auto-reload");
    wr(A_LOAD, 4'b1111, 32'd3);
    wr(A_CTRL, 4'b1111, 32'd3);
    idle(3);
    rd("timer_not_yet", A_PEND, 32'h0);
    rd("timer_fired", A_PEND, 32'h1);
    idle(2);
    wr(A_PEND, 4'b1111, 32'h1);
    rd("w1c_vs_fire", A_PEND, 32'h1);
    wr(A_PEND, 4'b1111, 32'h1);
    rd("w1c_cleared", A_PEND, 32'h0);

    $display("[TB] reset mid-run");
    wr(A_MASK, 4'b1111, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) pushTx(8'h50 + 8'(i), 1'b0);
    checkOutput("pre_reset_tx_valid", {31'd0, tx_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_interrupts", {16'd0, interrupts}, 32'd0);
    checkOutput("rst_read0", mem_read0_data, 32'd0);
    checkOutput("rst_read1", mem_read1_data, 32'd0);
    rd("rst_status", A_STATUS, 32'h1);
    rd("rst_load", A_LOAD, 32'd0);
    rd("rst_count", A_COUNT, 32'd0);
    rd("rst_ctrl", A_CTRL, 32'd0);
    rd("rst_pending", A_PEND, 32'd0);
    rd("rst_mask", A_MASK, 32'd0);
    rd("ram_survives_reset", 18'h10, 32'hDEAD55EF);
    checkOutput("rst_interrupts_after", {16'd0, interrupts}, 32'd0);

    idle(2);
    checkOutput("rd_queue_drained", rd_expect_q.size(), 32'd0);
    checkOutput("tx_queue_drained", tx_expect_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
